// File: rtl/spi_slave_rx_if.sv
// SPI pin bundle plus the byte-level RX/TX handshake of the mode-0 SPI slave front end.
interface spi_slave_rx_if;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] rxd_out;
    logic       rxd_flag;
    logic       frame_err;
    logic [7:0] txd_in;
    logic       txd_valid;
    logic       txd_ready;
    logic       busy;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, txd_in, txd_valid,
        output spi_miso, rxd_out, rxd_flag, frame_err, txd_ready, busy
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, txd_in, txd_valid,
        input  spi_miso, rxd_out, rxd_flag, frame_err, txd_ready, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI slave: oversamples the SPI pins on sys_clk, deserialises MOSI into bytes
// and shifts a host-supplied byte (or IDLE_TX_BYTE on underrun) out on MISO.
module spi_slave_rx #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] IDLE_TX_BYTE = 8'h00
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    spi_slave_rx_if.slave bus
);
    typedef enum logic [1:0] {WAIT_HIGH, IDLE, ACTIVE} state_e;

    // After reset the sync chains hold their reset values, not the real pins; WAIT_HIGH
    // must not trust cs_n until the chain has refilled, or a live frame would look idle.
    localparam int                SETTLE   = SYNC_STAGES + 1;
    localparam int                SW       = $clog2(SETTLE + 1);
    localparam logic [SW-1:0]     SETTLE_V = SW'(SETTLE);

    state_e                 state_q, state_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic                   sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic                   cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             hold_q, hold_d;
    logic                   full_q, full_d;
    logic [7:0]             rxd_out_q, rxd_out_d;
    logic                   rxd_flag_q, rxd_flag_d;
    logic                   frame_err_q, frame_err_d;
    logic                   miso_q, miso_d;
    logic                   sclk_s, cs_s, mosi_s, consume;
    logic [7:0]             tx_next;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign tx_next = full_q ? hold_q : IDLE_TX_BYTE;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise_d = sclk_s & ~sclk_prev_q;
        sclk_fall_d = ~sclk_s & sclk_prev_q;
        cs_rise_d   = cs_s & ~cs_prev_q;
        cs_fall_d   = ~cs_s & cs_prev_q;

        state_d     = state_q;
        settle_d    = settle_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        full_d      = full_q;
        rxd_out_d   = rxd_out_q;
        rxd_flag_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        consume     = 1'b0;

        case (state_q)
            WAIT_HIGH: begin
                if (settle_q == SETTLE_V) begin
                    if (cs_s) state_d = IDLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            IDLE: begin
                if (cs_fall_q) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'h00;
                    consume    = 1'b1;
                end
            end
            ACTIVE: begin
                // cs_n rise outranks any sclk edge seen in the same cycle
                if (cs_rise_q) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != 3'd0);
                    rx_shift_d  = 8'h00;
                end else if (sclk_rise_q) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rxd_out_d  = {rx_shift_q[6:0], mosi_s};
                        rxd_flag_d = 1'b1;
                    end
                end else if (sclk_fall_q) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end else begin
                        consume = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_HIGH;
        endcase

        if (consume) begin
            tx_shift_d = tx_next;
            miso_d     = tx_next[7];
            full_d     = 1'b0;
        end
        // Load only when empty, so it never races the consume above.
        if (bus.txd_valid && !full_q) begin
            hold_d = bus.txd_in;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= WAIT_HIGH;
            settle_q    <= '0;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            full_q      <= 1'b0;
            rxd_out_q   <= 8'h00;
            rxd_flag_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            rxd_out_q   <= rxd_out_d;
            rxd_flag_q  <= rxd_flag_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
        end
    end

    assign bus.spi_miso  = miso_q;
    assign bus.rxd_out   = rxd_out_q;
    assign bus.rxd_flag  = rxd_flag_q;
    assign bus.frame_err = frame_err_q;
    assign bus.txd_ready = ~full_q;
    assign bus.busy      = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: acts as SPI master, counts strobes, checks bytes and MISO.
module tb_spi_slave_rx;
    localparam int HALF = 8;   // sclk half period in sys_clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_rx_if bus();
    spi_slave_rx dut (.sys_clk(clk), .sys_rst(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_err = 0;
    int flag_cnt = 0, ferr_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
    logic [7:0] rx_log [0:15];
    logic prev_flag = 1'b0, prev_ferr = 1'b0;

    always @(negedge clk) begin
        if (bus.rxd_flag) begin
            if (flag_cnt < 16) rx_log[flag_cnt] = bus.rxd_out;
            flag_cnt++;
        end
        if (bus.frame_err) ferr_cnt++;
        if (bus.rxd_flag && bus.frame_err) overlap_cnt++;
        if ((bus.rxd_flag && prev_flag) || (bus.frame_err && prev_ferr)) wide_cnt++;
        prev_flag = bus.rxd_flag;
        prev_ferr = bus.frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shifts the top n bits of data out MSB first; returns MISO sampled at each rise.
    task automatic spi_bits(input logic [7:0] data, input int n, output logic [7:0] miso);
        logic [7:0] d;
        d = data;
        miso = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.spi_mosi = d[7];
            d = {d[6:0], 1'b0};
            cyc(HALF);
            miso = {miso[6:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            cyc(HALF);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low;
        bus.spi_cs_n = 1'b0;
        cyc(HALF);
    endtask

    task automatic cs_high;
        cyc(HALF);
        bus.spi_cs_n = 1'b1;
        cyc(10);
    endtask

    task automatic push_tx(input logic [7:0] b);
        bus.txd_in = b;
        bus.txd_valid = 1'b1;
        cyc(1);
        bus.txd_valid = 1'b0;
    endtask

    logic [7:0] mb, mb2;
    int f0, e0;

    initial begin
        bus.spi_sclk = 1'b0; bus.spi_cs_n = 1'b1; bus.spi_mosi = 1'b0;
        bus.txd_in = 8'h00; bus.txd_valid = 1'b0;
        cyc(5);
        chk("rst_rxd_out", bus.rxd_out, 8'h00);
        chk("rst_rxd_flag", bus.rxd_flag, 1'b0);
        chk("rst_frame_err", bus.frame_err, 1'b0);
        chk("rst_miso", bus.spi_miso, 1'b0);
        chk("rst_txd_ready", bus.txd_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        cyc(10);

        // single byte
        cs_low();
        chk("single_busy", bus.busy, 1'b1);
        spi_bits(8'hA5, 8, mb);
        cs_high();
        chk("single_flags", flag_cnt, 1);
        chk("single_byte", rx_log[0], 8'hA5);
        chk("single_ferr", ferr_cnt, 0);
        chk("single_hold", bus.rxd_out, 8'hA5);
        chk("single_idle_busy", bus.busy, 1'b0);

        // full duplex
        push_tx(8'h3C);
        chk("fd_ready_low", bus.txd_ready, 1'b0);
        cs_low();
        chk("fd_ready_back", bus.txd_ready, 1'b1);
        spi_bits(8'hC3, 8, mb);
        cs_high();
        chk("fd_miso", mb, 8'h3C);
        chk("fd_rxd", bus.rxd_out, 8'hC3);
        chk("fd_flags", flag_cnt, 2);

        // two-byte frame
        push_tx(8'hAA);
        cs_low();
        push_tx(8'h56);
        spi_bits(8'h12, 8, mb);
        spi_bits(8'h34, 8, mb2);
        cs_high();
        chk("two_flags", flag_cnt, 4);
        chk("two_b0", rx_log[2], 8'h12);
        chk("two_b1", rx_log[3], 8'h34);
        chk("two_miso0", mb, 8'hAA);
        chk("two_miso1", mb2, 8'h56);
        chk("two_ferr", ferr_cnt, 0);

        // abort after 5 bits
        cs_low();
        spi_bits(8'h0F, 5, mb);
        cs_high();
        chk("abort_ferr", ferr_cnt, 1);
        chk("abort_flags", flag_cnt, 4);
        chk("abort_hold", bus.rxd_out, 8'h34);
        cs_low();
        spi_bits(8'hFF, 8, mb);
        cs_high();
        chk("abort_next", bus.rxd_out, 8'hFF);
        chk("abort_next_flags", flag_cnt, 5);

        // reset mid-frame
        f0 = flag_cnt; e0 = ferr_cnt;
        cs_low();
        spi_bits(8'hF0, 3, mb);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        spi_bits(8'h80, 5, mb);
        chk("rmf_busy", bus.busy, 1'b0);
        cs_high();
        chk("rmf_no_flag", flag_cnt, f0);
        chk("rmf_no_ferr", ferr_cnt, e0);
        chk("rmf_rxd_cleared", bus.rxd_out, 8'h00);
        cs_low();
        spi_bits(8'h81, 8, mb);
        cs_high();
        chk("rmf_next", bus.rxd_out, 8'h81);
        chk("rmf_next_flags", flag_cnt, f0 + 1);

        // TX underrun
        cs_low();
        spi_bits(8'h5A, 8, mb);
        cs_high();
        chk("ur_miso", mb, 8'h00);
        chk("ur_rxd", bus.rxd_out, 8'h5A);

        chk("strobe_overlap", overlap_cnt, 0);
        chk("strobe_width", wide_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Mode-0 SPI slave front end, running on `sys_clk`. It oversamples the external SPI pins, deserialises MOSI into bytes, and presents each completed byte on `rxd_out` with a one-cycle `rxd_flag` strobe. Those two outputs are the signals the on-chip analyser probes. In the same frame it serialises a host-supplied byte onto MISO. Downstream command/register logic consumes `rxd_out`/`rxd_flag` and feeds `txd_in`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in each pin synchroniser (≥2).
- `IDLE_TX_BYTE`, 8'h00: byte shifted out when the TX holding register is empty (underrun).

Ports:
- `sys_clk`  in  1  system clock; only clock in the block.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `spi_sclk`  in  1  SPI clock, asynchronous; CPOL=0, CPHA=0.
- `spi_cs_n`  in  1  chip select, active-low, asynchronous.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first, registered.
- `rxd_out`  out  8  last complete received byte; held until the next byte completes.
- `rxd_flag`  out  1  one-cycle strobe: `rxd_out` was updated this cycle.
- `frame_err`  out  1  one-cycle strobe: CS deasserted mid-byte.
- `txd_in`  in  8  byte to transmit.
- `txd_valid`  in  1  `txd_in` is valid.
- `txd_ready`  out  1  holding register empty; a transfer occurs when `txd_valid & txd_ready`.
- `busy`  out  1  high while state is ACTIVE.

## Operation
- **Synchronisers.** Each of `spi_sclk`, `spi_cs_n` and `spi_mosi` passes through `SYNC_STAGES` flops.
  - Reset values: sclk=0, cs_n=1, mosi=0.
  - One extra flop on synced sclk and cs_n gives rise/fall detection.
- **States:**
  - WAIT_HIGH: reset state. Moves to IDLE when synced cs_n=1. This guarantees a frame already in progress at reset is never partially captured.
  - IDLE: on synced cs_n falling → ACTIVE. On entry: `bit_cnt`=0, TX shift ← holding (or `IDLE_TX_BYTE` if empty), holding marked empty, `spi_miso` ← bit 7 of the loaded byte.
  - ACTIVE:
    - sclk rise: `rx_shift` ← {`rx_shift[6:0]`, mosi}, then `bit_cnt`++ (3-bit, wraps 7→0).
    - sclk rise when `bit_cnt`==7: `rxd_out` ← {`rx_shift[6:0]`, mosi}, `rxd_flag`=1 the same cycle `rxd_out` updates.
    - sclk fall with `bit_cnt`!=0: TX shift left by one, `spi_miso` ← new bit 7.
    - sclk fall with `bit_cnt`==0 (byte boundary): reload TX shift from holding (or `IDLE_TX_BYTE`), holding emptied, `spi_miso` ← bit 7.
    - synced cs_n rise → IDLE. If `bit_cnt`!=0, pulse `frame_err` and discard the partial `rx_shift`; no `rxd_flag`.
- **TX holding register** (8 bits plus a full bit):
  - Loaded when `txd_valid & txd_ready`.
  - `txd_ready` = !full.
  - Emptied only when moved into the TX shift register.
- **Simultaneous events:** a cs_n rise in the same cycle as an sclk edge wins; that sclk edge is ignored. A holding-register load and a consume in the same cycle cannot collide, because load requires empty.
- `spi_miso` is always driven; it is not tri-stated.

## Timing
- **Reset values:** `rxd_out`=0, `rxd_flag`=0, `frame_err`=0, `spi_miso`=0, `txd_ready`=1, `busy`=0, state WAIT_HIGH.
- **Reset mid-frame:** reset aborts the frame with no strobes, then waits for cs_n high.
- **RX latency:** `rxd_flag` is asserted `SYNC_STAGES`+2 `sys_clk` cycles after the 8th pin-level sclk rise (sync chain, edge detect, register).
- **MISO latency:** `spi_miso` changes `SYNC_STAGES`+2 cycles after a pin-level sclk fall or cs_n fall.
- **SCLK limits:** high and low times must each be ≥ `SYNC_STAGES`+3 `sys_clk` periods, i.e. sclk ≤ `sys_clk`/10 at default.
- **CS setup:** first sclk rise ≥ `SYNC_STAGES`+3 cycles after cs_n fall.
- **Strobes:** `rxd_flag` and `frame_err` are exactly one cycle wide and never asserted together.
- **Byte rate:** byte-to-byte `rxd_flag` spacing ≥ 8 sclk periods. Back-to-back bytes within one frame need no CS toggle.

## Test plan
- **Single byte receive:** reset, CS low, send 0xA5 → exactly one `rxd_flag`, `rxd_out`=0xA5, `frame_err`=0, `rxd_out` holds 0xA5 after CS high.
- **Full duplex:** `txd_in`=0x3C accepted before CS falls, master sends 0xC3 → MISO bits 0,0,1,1,1,1,0,0; `rxd_out`=0xC3; `txd_ready` returns to 1 at CS fall.
- **Two-byte frame:** send 0x12, 0x34 in one CS window, loading TX 0x56 during byte 0 → two `rxd_flag` pulses with 0x12 then 0x34; byte-1 MISO = 0x56, byte-0 MISO = preloaded value.
- **Abort:** CS high after 5 bits → one `frame_err` pulse, no `rxd_flag`, `rxd_out` unchanged. Next full frame 0xFF → `rxd_out`=0xFF.
- **Reset mid-frame:** assert `sys_rst` after 3 bits with CS held low, finish the byte → no strobes. CS high, then new frame 0x81 → `rxd_out`=0x81.
- **TX underrun:** no `txd_valid`, send 0x5A → MISO all `IDLE_TX_BYTE` bits (0x00), RX still 0x5A.
